// File: rtl/saturating_differentiator.sv
// Streaming differentiator: y[n] = x[n] - x[n-DIFF_DELAY], saturated to DATA_SZ bits.
// Latency 1 cycle from input acceptance; in_ready drops while the output register is held.
module saturating_differentiator #(
  parameter int ACCUM_SZ   = 32,
  parameter int DATA_SZ    = 16,
  parameter int DIFF_DELAY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [ACCUM_SZ-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_SZ-1:0]  out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                sat_flag
);

  localparam int CNT_W = (DIFF_DELAY > 1) ? $clog2(DIFF_DELAY) : 1;
  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(DIFF_DELAY - 1);
  localparam logic [DATA_SZ-1:0] SAT_POS = {1'b0, {(DATA_SZ-1){1'b1}}};
  localparam logic [DATA_SZ-1:0] SAT_NEG = {1'b1, {(DATA_SZ-1){1'b0}}};

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_prime_cnt;
  logic [ACCUM_SZ-1:0] r_hist [DIFF_DELAY];
  logic [DATA_SZ-1:0]  r_out_data;
  logic                r_out_valid;
  logic                r_sat_flag;

  logic                w_accept;
  logic                w_consume;
  logic                w_run_load;
  logic                w_prime_inc;
  logic [ACCUM_SZ:0]   w_diff;
  logic [ACCUM_SZ:0]   w_hist_ext;
  logic [ACCUM_SZ:0]   w_in_ext;
  logic [ACCUM_SZ-DATA_SZ+1:0] w_diff_hi;
  logic                w_ovf;
  logic [DATA_SZ-1:0]  w_sat_data;

  assign in_ready  = !clear && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  // One extra bit makes the subtraction exact for any pair of ACCUM_SZ inputs.
  assign w_in_ext   = {in_data[ACCUM_SZ-1], in_data};
  assign w_hist_ext = {r_hist[DIFF_DELAY-1][ACCUM_SZ-1], r_hist[DIFF_DELAY-1]};
  assign w_diff     = w_in_ext - w_hist_ext;

  // The value fits in DATA_SZ bits only if every bit from DATA_SZ-1 upward matches the sign.
  assign w_diff_hi = w_diff[ACCUM_SZ:DATA_SZ-1];
  assign w_ovf     = !((&w_diff_hi) || !(|w_diff_hi));

  always_comb begin
    w_sat_data = w_diff[DATA_SZ-1:0];
    if (w_ovf) begin
      w_sat_data = w_diff[ACCUM_SZ] ? SAT_NEG : SAT_POS;
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = PRIME;
    end else begin
      case (r_state)
        PRIME:   if (w_accept && (r_prime_cnt == PRIME_LAST)) w_state_nxt = RUN;
        RUN:     w_state_nxt = RUN;
        default: w_state_nxt = PRIME;
      endcase
    end
  end

  // State-decoded controls
  always_comb begin
    w_run_load  = 1'b0;
    w_prime_inc = 1'b0;
    case (r_state)
      PRIME:   w_prime_inc = w_accept && (r_prime_cnt != PRIME_LAST);
      RUN:     w_run_load  = w_accept;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prime_cnt <= '0;
    end else if (clear) begin
      r_prime_cnt <= '0;
    end else if (w_prime_inc) begin
      r_prime_cnt <= r_prime_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DIFF_DELAY; i++) r_hist[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DIFF_DELAY; i++) r_hist[i] <= '0;
    end else if (w_accept) begin
      r_hist[0] <= in_data;
      for (int i = 1; i < DIFF_DELAY; i++) r_hist[i] <= r_hist[i-1];
    end
  end

  // A load in the same cycle as a consume replaces the old result and keeps valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else if (clear) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sat_flag  <= 1'b0;
    end else if (w_run_load) begin
      r_out_data  <= w_sat_data;
      r_out_valid <= 1'b1;
      r_sat_flag  <= r_sat_flag | w_ovf;
    end else if (w_consume) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_saturating_differentiator.sv
// Directed bench for saturating_differentiator with DIFF_DELAY=1 and DIFF_DELAY=3 instances.
module tb_saturating_differentiator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_sat;
  logic [31:0] a_in_data;
  logic [15:0] a_out_data;
  logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sat;
  logic [31:0] b_in_data;
  logic [15:0] b_out_data;

  int checks   = 0;
  int failures = 0;

  saturating_differentiator #(.ACCUM_SZ(32), .DATA_SZ(16), .DIFF_DELAY(1)) u_d1 (
    .clk(clk), .reset(reset), .clear(a_clear),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .sat_flag(a_sat)
  );

  saturating_differentiator #(.ACCUM_SZ(32), .DATA_SZ(16), .DIFF_DELAY(3)) u_d3 (
    .clk(clk), .reset(reset), .clear(b_clear),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .sat_flag(b_sat)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are read on the following falling edge.
  task automatic a_step(input logic v, input logic [31:0] d);
    a_in_valid = v;
    a_in_data  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic b_step(input logic v, input logic [31:0] d);
    b_in_valid = v;
    b_in_data  = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n_out;
    int b_vals [5] = '{10, 20, 30, 45, 70};
    int b_expv [5] = '{0, 0, 0, 1, 1};
    int b_expd [5] = '{0, 0, 0, 35, 50};

    reset = 1'b0;
    a_clear = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_clear = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;

    @(negedge clk);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_sat", a_sat, 0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", a_in_ready, 1);

    // Basic differencing, M=1
    a_step(1, 100);
    chk("prime_no_valid", a_out_valid, 0);
    a_step(1, 150);
    chk("d1_valid_50", a_out_valid, 1);
    chk("d1_data_50", $signed(a_out_data), 50);
    a_step(1, 140);
    chk("d1_data_m10", $signed(a_out_data), -10);
    a_step(0, 0);
    chk("d1_consumed", a_out_valid, 0);
    chk("d1_no_sat", a_sat, 0);

    // Saturation in both directions
    a_clear = 1'b1; a_step(0, 0); a_clear = 1'b0;
    a_step(1, 0);
    chk("sat_prime", a_out_valid, 0);
    a_step(1, 40000);
    chk("sat_pos_data", $signed(a_out_data), 32767);
    chk("sat_pos_flag", a_sat, 1);
    a_step(1, 0);
    chk("sat_neg_data", $signed(a_out_data), -32768);
    chk("sat_sticky", a_sat, 1);

    // Full-range operands: the difference must not wrap
    a_step(1, 32'h7FFF_FFFF);
    chk("full_pos_data", $signed(a_out_data), 32767);
    a_step(1, 32'h8000_0000);
    chk("full_neg_data", $signed(a_out_data), -32768);
    chk("full_neg_flag", a_sat, 1);

    // Back-pressure
    a_clear = 1'b1; a_step(0, 0); a_clear = 1'b0;
    chk("clear_sat", a_sat, 0);
    a_step(1, 10);
    a_step(1, 25);
    chk("bp_first", $signed(a_out_data), 15);
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 60;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_in_ready_low", a_in_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_data_stable", $signed(a_out_data), 15);
      chk("bp_valid_held", a_out_valid, 1);
    end
    a_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", a_in_ready, 1);
    a_step(1, 60);
    chk("bp_resume_35", $signed(a_out_data), 35);
    chk("bp_resume_valid", a_out_valid, 1);
    a_step(1, 61);
    chk("bp_next_1", $signed(a_out_data), 1);
    a_step(1, 70000);
    chk("bp_sat_data", $signed(a_out_data), 32767);
    chk("bp_sat_flag", a_sat, 1);

    // Clear while an output is pending and an input is offered
    a_clear    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 500;
    #1;
    chk("clr_in_ready", a_in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    chk("clr_out_valid", a_out_valid, 0);
    chk("clr_sat", a_sat, 0);
    a_clear = 1'b0;
    a_step(1, 500);
    chk("clr_reprime", a_out_valid, 0);
    a_step(1, 510);
    chk("clr_after_data", $signed(a_out_data), 10);

    // Asynchronous reset mid-stream
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", a_out_valid, 0);
    chk("arst_data", a_out_data, 0);
    chk("arst_sat", a_sat, 0);
    @(negedge clk);
    reset = 1'b1;
    a_step(1, 7);
    chk("arst_reprime", a_out_valid, 0);
    a_step(1, 9);
    chk("arst_data_2", $signed(a_out_data), 2);
    a_step(0, 0);

    // M=3 instance
    n_out = 0;
    for (int i = 0; i < 5; i++) begin
      b_step(1, b_vals[i]);
      if (b_out_valid) n_out++;
      chk("d3_valid", b_out_valid, b_expv[i]);
      if (b_expv[i] != 0) chk("d3_data", $signed(b_out_data), b_expd[i]);
    end
    b_step(0, 0);
    chk("d3_idle", b_out_valid, 0);
    chk("d3_count", n_out, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
